// File: rtl/avalon_sync_pipeline_bridge_if.sv
// Avalon-MM bus bundle. One instance per side of the bridge: the system side carries
// word addresses and the peripheral side carries byte addresses, so AW differs per instance.
interface avalon_sync_pipeline_bridge_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 8
);
    localparam int BE_W = DATA_W / 8;

    logic [AW-1:0]     address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              endofpacket;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, endofpacket, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, endofpacket, readdatavalid
    );
endinterface

// File: rtl/avalon_sync_pipeline_bridge.sv
// Avalon-MM pipeline bridge: show-ahead command FIFO toward the peripheral, response FIFO
// back to the system, and a read-credit counter that keeps the response FIFO from overflowing.
module avalon_sync_pipeline_bridge #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int CMD_DEPTH   = 16,
    parameter int RSP_DEPTH   = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    avalon_sync_pipeline_bridge_if.slave  sys,
    avalon_sync_pipeline_bridge_if.master per,
    output logic [7:0]                    pending_reads,
    output logic                          protocol_err
);
    localparam int BE_W = DATA_W / 8;
    localparam int LSB  = $clog2(BE_W);
    localparam int MA_W = ADDR_W + LSB;
    localparam int CW   = $clog2(CMD_DEPTH);
    localparam int RW   = $clog2(RSP_DEPTH);

    logic [DATA_W-1:0] cmd_data [CMD_DEPTH];
    logic [ADDR_W-1:0] cmd_addr [CMD_DEPTH];
    logic [BE_W-1:0]   cmd_be   [CMD_DEPTH];
    logic              cmd_rd   [CMD_DEPTH];
    logic              cmd_wr   [CMD_DEPTH];
    logic [CW-1:0]     cmd_wp, cmd_rp;
    logic [CW:0]       cmd_cnt;
    logic              cmd_full, cmd_empty, cmd_push, cmd_pop, both_err;

    logic [DATA_W-1:0] rsp_data [RSP_DEPTH];
    logic              rsp_eop  [RSP_DEPTH];
    logic [RW-1:0]     rsp_wp, rsp_rp;
    logic [RW:0]       rsp_cnt;
    logic              rsp_full, rsp_push, rsp_pop;

    logic              rd_acc, rsp_spur, rsp_dec;
    logic              vld_p1, eop_p1;
    logic [DATA_W-1:0] data_p1;

    assign cmd_full        = (cmd_cnt == (CW+1)'(CMD_DEPTH));
    assign cmd_empty       = (cmd_cnt == '0);
    assign cmd_push        = !reset && (sys.read || sys.write) && !cmd_full;
    assign both_err        = cmd_push && sys.read && sys.write;
    assign sys.waitrequest = reset || cmd_full;

    // Command FIFO storage; a read+write collision is kept as a write only.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_data[cmd_wp] <= sys.writedata;
            cmd_addr[cmd_wp] <= sys.address;
            cmd_be[cmd_wp]   <= sys.byteenable;
            cmd_rd[cmd_wp]   <= sys.read && !sys.write;
            cmd_wr[cmd_wp]   <= sys.write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
            if (cmd_pop)  cmd_rp <= cmd_rp + 1'b1;
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
                2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
                default: cmd_cnt <= cmd_cnt;
            endcase
        end
    end

    // Master side is the FIFO head, shown combinationally; a credit-starved read blocks everything behind it.
    assign per.read       = !reset && !cmd_empty && cmd_rd[cmd_rp] && (pending_reads < 8'(MAX_PENDING));
    assign per.write      = !reset && !cmd_empty && cmd_wr[cmd_rp];
    assign per.address    = MA_W'(cmd_addr[cmd_rp]) << LSB;
    assign per.byteenable = cmd_be[cmd_rp];
    assign per.writedata  = cmd_data[cmd_rp];
    assign cmd_pop        = (per.read || per.write) && !per.waitrequest;

    assign rd_acc   = per.read && !per.waitrequest;
    assign rsp_spur = per.readdatavalid && (pending_reads == 8'd0);
    assign rsp_dec  = per.readdatavalid && !rsp_spur;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reads <= 8'd0;
            protocol_err  <= 1'b0;
        end else begin
            if (rd_acc && !rsp_dec)      pending_reads <= pending_reads + 8'd1;
            else if (!rd_acc && rsp_dec) pending_reads <= pending_reads - 8'd1;
            if (both_err || rsp_spur)    protocol_err  <= 1'b1;
        end
    end

    // Response FIFO: every returning beat is kept, spurious ones included.
    assign rsp_full = (rsp_cnt == (RW+1)'(RSP_DEPTH));
    assign rsp_push = !reset && per.readdatavalid;
    assign rsp_pop  = !reset && (rsp_cnt != '0);

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            rsp_data[rsp_wp] <= per.readdata;
            rsp_eop[rsp_wp]  <= per.endofpacket;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_wp  <= '0;
            rsp_rp  <= '0;
            rsp_cnt <= '0;
        end else begin
            if (rsp_push) rsp_wp <= rsp_wp + 1'b1;
            if (rsp_pop)  rsp_rp <= rsp_rp + 1'b1;
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_cnt <= rsp_cnt + 1'b1;
                2'b01:   rsp_cnt <= rsp_cnt - 1'b1;
                default: rsp_cnt <= rsp_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(rsp_push && rsp_full)) else $error("response FIFO overflow");
    end

    // Stage p1: registered slave-side response.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            eop_p1  <= 1'b0;
        end else begin
            vld_p1 <= rsp_pop;
            if (rsp_pop) begin
                data_p1 <= rsp_data[rsp_rp];
                eop_p1  <= rsp_eop[rsp_rp];
            end
        end
    end

    assign sys.readdatavalid = vld_p1;
    assign sys.readdata      = data_p1;
    assign sys.endofpacket   = eop_p1;
endmodule

// File: doc/avalon_sync_pipeline_bridge.md
# avalon_sync_pipeline_bridge

Single-clock, parametrised Avalon-MM pipeline bridge between a system-side slave port and a peripheral-side master port. It buffers commands in a show-ahead command FIFO and read responses in a response FIFO. It bounds outstanding reads with a credit counter, so the response FIFO can never overflow; this replaces threshold-based almost-full throttling. It sits in front of slow or deeply pipelined peripherals that share the system clock, and it is generic in data width, address width and FIFO depths.

## Interface
- DATA_W, 32: data width in bits (multiple of 8); BE_W = DATA_W/8
- ADDR_W, 8: slave word-address width; master byte address is ADDR_W+log2(BE_W) bits
- CMD_DEPTH, 16: command FIFO entries (power of 2, ≥2)
- RSP_DEPTH, 16: response FIFO entries (power of 2, ≥ MAX_PENDING)
- MAX_PENDING, 8: maximum issued-but-unanswered master reads (1..255)

Ports:
- clk  in  1  single clock for both ports (one clock)
- reset  in  1  synchronous, active-high reset
- slave_address  in  ADDR_W  word address
- slave_byteenable  in  BE_W
- slave_read / slave_write  in  1 each
- slave_writedata  in  DATA_W
- slave_waitrequest  out  1  command not accepted this cycle
- slave_readdata  out  DATA_W;  slave_endofpacket  out  1
- slave_readdatavalid  out  1
- master_address  out  ADDR_W+log2(BE_W)  byte address = {word address, zeros}
- master_byteenable  out  BE_W;  master_writedata  out  DATA_W
- master_read / master_write  out  1 each
- master_waitrequest  in  1
- master_readdata  in  DATA_W;  master_endofpacket  in  1;  master_readdatavalid  in  1
- pending_reads  out  8  current credit-counter value
- protocol_err  out  1  sticky error flag, cleared only by reset

## Operation
- Command FIFO entry: {writedata, address, read, write, byteenable}.
- Push when (slave_read|slave_write) & !cmd_full.
- slave_waitrequest = reset | cmd_full.
- If read and write are both asserted: store as a write only, drop the read, set protocol_err.
- Master side presents the FIFO head combinationally while the FIFO is non-empty.
- master_write = head.write.
- master_read = head.read & (pending_reads < MAX_PENDING).
- A read blocked by credit stalls the head; strict in-order issue, so later writes also wait.
- Pop the head when (master_read|master_write) & !master_waitrequest.
- Address, data and byteenable stay stable while waitrequest is high.
- Credit counter:
  - +1 on an accepted read (master_read & !master_waitrequest).
  - −1 on master_readdatavalid.
  - Both in the same cycle: unchanged.
- readdatavalid with pending_reads==0: counter stays at 0, data is still forwarded, protocol_err is set.
- Response FIFO entry: {readdata, endofpacket}. Push on master_readdatavalid; pop whenever non-empty.
- slave_readdata, slave_endofpacket and slave_readdatavalid are registered from the popped entry.
- slave_readdatavalid = 1 for exactly one cycle per popped entry.
- Response FIFO full-with-push cannot occur (RSP_DEPTH ≥ MAX_PENDING). Simulation assertion required.

## Timing
- Reset values:
  - slave_waitrequest=1 while reset is high, 0 in the first cycle after reset.
  - slave_readdatavalid=0, slave_readdata=0, slave_endofpacket=0.
  - master_read=0, master_write=0.
  - pending_reads=0, protocol_err=0.
  - Both FIFOs empty.
- Reset mid-operation: in-flight commands and responses are discarded. Responses arriving after reset are treated as spurious (protocol_err set).
- Command latency: slave command accepted in cycle N appears on master_* in cycle N+1 (empty FIFO, no waitrequest).
- Response latency: master_readdatavalid in cycle N gives slave_readdatavalid in cycle N+2.
- Throughput: one command per cycle and one response per cycle sustained.
- Simultaneous FIFO push and pop while full: push refused (waitrequest is high); the pop proceeds.
- Simultaneous FIFO push and pop while empty: the pushed entry becomes head next cycle.
- FIFO pointers wrap modulo depth; level counters are log2(depth)+1 bits wide.

## Test plan
- Single write 0x12, data 0xDEADBEEF, be 0xF → master_write in cycle N+1 with address 0x048, held through 3 waitrequest cycles, popped once.
- Burst of 16 writes with master_waitrequest stuck high (CMD_DEPTH=16) → slave_waitrequest asserts on the 17th command; releasing the master drains all 16 in order.
- 10 back-to-back reads, peripheral responding only after 20 cycles (MAX_PENDING=8) → pending_reads saturates at 8, 9th read held; all 10 readdata returned in order, each 2 cycles after the master-side valid.
- Read issued in the same cycle as a returning readdatavalid → pending_reads unchanged; readdatavalid with pending_reads==0 → protocol_err=1 and sticky.
- Mixed read, write, read to the same address → master sees the exact order; the second read returns the written value; endofpacket bit passes through.
- Reset asserted with 5 queued commands and 3 pending reads → next cycle all outputs are at reset values, FIFOs are empty, pending_reads=0.
